// File: rtl/mosby_pkg.sv
// Shared definitions for the MOSby 6502 front end: bus widths, reset vector,
// instruction-length codes and fetch FSM state codes.
package mosby_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned LEN_W  = 2;
  localparam int unsigned ST_W   = 3;

  localparam logic [ADDR_W-1:0] RESET_VECTOR_DEF = 16'hFFFC;

  localparam logic [LEN_W-1:0] LEN_1 = 2'd1;
  localparam logic [LEN_W-1:0] LEN_2 = 2'd2;
  localparam logic [LEN_W-1:0] LEN_3 = 2'd3;

  typedef logic [ST_W-1:0] state_t;

  localparam state_t ST_VEC_LO   = 3'd0;
  localparam state_t ST_VEC_HI   = 3'd1;
  localparam state_t ST_FETCH_OP = 3'd2;
  localparam state_t ST_FETCH_LO = 3'd3;
  localparam state_t ST_FETCH_HI = 3'd4;
  localparam state_t ST_HOLD     = 3'd5;

endpackage

// File: rtl/opcode_length.sv
// 6502 instruction length decode from the opcode byte (1, 2 or 3 bytes).
// Purely combinational; also reused by the decoder.
module opcode_length
  import mosby_pkg::*;
(
  input  logic [DATA_W-1:0] op,
  output logic [LEN_W-1:0]  len
);

  logic is_len1;
  logic is_len3;

  always_comb begin
    is_len1 = (op[3:0] == 4'h8) || (op[3:0] == 4'hA) ||
              (op == 8'h00) || (op == 8'h40) || (op == 8'h60);
    is_len3 = (op[3:2] == 2'b11) || (op[4:0] == 5'b11001) || (op == 8'h20);
    len = LEN_2;
    if (is_len1) begin
      len = LEN_1;
    end else if (is_len3) begin
      len = LEN_3;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// MOSby 6502 instruction fetch: loads the reset vector, then fetches one
// instruction at a time and hands it to the decoder over valid/ready.
module fetch_unit
  import mosby_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_VECTOR = RESET_VECTOR_DEF
) (
  input  logic              clk_1,
  input  logic              rst,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              mem_rdy,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_in,
  output logic [15:0]       instruction,
  output logic [DATA_W-1:0] operand_hi,
  output logic [LEN_W-1:0]  instr_len,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready
);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0]   opcode_q, opcode_d;
  logic [DATA_W-1:0]   operand_lo_q, operand_lo_d;
  logic [DATA_W-1:0]   operand_hi_q, operand_hi_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [ADDR_W-1:0]   instr_pc_q, instr_pc_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                mem_rd_q, mem_rd_d;
  logic                instr_valid_q, instr_valid_d;
  logic [LEN_W-1:0]    op_len_c;

  opcode_length u_opcode_length (
    .op  (mem_data),
    .len (op_len_c)
  );

  // Next state and datapath; memory-side outputs are precomputed from the next state.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    opcode_d     = opcode_q;
    operand_lo_d = operand_lo_q;
    operand_hi_d = operand_hi_q;
    len_d        = len_q;
    instr_pc_d   = instr_pc_q;

    case (state_q)
      ST_VEC_LO: if (mem_rdy) begin
        pc_d[7:0] = mem_data;
        state_d   = ST_VEC_HI;
      end
      ST_VEC_HI: if (mem_rdy) begin
        pc_d[15:8] = mem_data;
        state_d    = ST_FETCH_OP;
      end
      ST_FETCH_OP: if (mem_rdy) begin
        opcode_d     = mem_data;
        operand_lo_d = '0;
        operand_hi_d = '0;
        len_d        = op_len_c;
        instr_pc_d   = pc_q;
        pc_d         = pc_q + 16'd1;
        state_d      = (op_len_c == LEN_1) ? ST_HOLD : ST_FETCH_LO;
      end
      ST_FETCH_LO: if (mem_rdy) begin
        operand_lo_d = mem_data;
        pc_d         = pc_q + 16'd1;
        state_d      = (len_q == LEN_2) ? ST_HOLD : ST_FETCH_HI;
      end
      ST_FETCH_HI: if (mem_rdy) begin
        operand_hi_d = mem_data;
        pc_d         = pc_q + 16'd1;
        state_d      = ST_HOLD;
      end
      ST_HOLD: if (instr_ready) begin
        state_d = ST_FETCH_OP;
      end
      default: state_d = ST_VEC_LO;
    endcase

    // Redirect wins over everything once the vector is loaded, abandoning any partial fetch.
    if (pc_load && (state_q != ST_VEC_LO) && (state_q != ST_VEC_HI)) begin
      pc_d    = pc_in;
      state_d = ST_FETCH_OP;
    end

    mem_rd_d      = (state_d != ST_HOLD);
    instr_valid_d = (state_d == ST_HOLD);
    case (state_d)
      ST_VEC_LO: mem_addr_d = RESET_VECTOR;
      ST_VEC_HI: mem_addr_d = RESET_VECTOR + 16'd1;
      default:   mem_addr_d = pc_d;
    endcase
  end

  always_ff @(posedge clk_1 or posedge rst) begin
    if (rst) begin
      state_q       <= ST_VEC_LO;
      pc_q          <= '0;
      opcode_q      <= '0;
      operand_lo_q  <= '0;
      operand_hi_q  <= '0;
      len_q         <= '0;
      instr_pc_q    <= '0;
      mem_addr_q    <= RESET_VECTOR;
      mem_rd_q      <= 1'b1;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      opcode_q      <= opcode_d;
      operand_lo_q  <= operand_lo_d;
      operand_hi_q  <= operand_hi_d;
      len_q         <= len_d;
      instr_pc_q    <= instr_pc_d;
      mem_addr_q    <= mem_addr_d;
      mem_rd_q      <= mem_rd_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  assign mem_addr    = mem_addr_q;
  assign mem_rd      = mem_rd_q;
  assign instruction = {operand_lo_q, opcode_q};
  assign operand_hi  = operand_hi_q;
  assign instr_len   = len_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

- Instruction fetch unit for the MOSby 6502 core; the producer side of the decoder's `instruction` input.
- After reset it reads the reset vector at 0xFFFC/0xFFFD, then walks memory byte by byte.
- For each opcode it determines the instruction length (1–3 bytes) and assembles opcode and operands.
- It presents the result to the decoder over a valid/ready handshake. The execute stage redirects it on jumps and branches through `pc_load`.

## Interface
Parameters:
- `RESET_VECTOR`, default 16'hFFFC: address of the reset-vector low byte; the high byte is at `RESET_VECTOR+1`.

Ports:
- `clk_1`  in  1  sole clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `mem_addr`  out  16  byte address of the current read.
- `mem_rd`  out  1  read request.
- `mem_data`  in  8  read data; valid when `mem_rd && mem_rdy`.
- `mem_rdy`  in  1  memory completes the read this cycle.
- `pc_load`  in  1  redirect request.
- `pc_in`  in  16  redirect target.
- `instruction`  out  16  {operand_lo, opcode}.
- `operand_hi`  out  8  third byte of 3-byte instructions.
- `instr_len`  out  2  1, 2 or 3.
- `instr_pc`  out  16  address of the opcode byte.
- `instr_valid`  out  1  an instruction is presented.
- `instr_ready`  in  1  the decoder accepts it.

## Operation
States and transitions:
- VEC_LO: read `RESET_VECTOR` → pc[7:0]; go to VEC_HI.
- VEC_HI: read `RESET_VECTOR+1` → pc[15:8]; go to FETCH_OP.
- FETCH_OP: read pc → opcode; pc+1; go to HOLD if len=1, else FETCH_LO.
- FETCH_LO: read pc → operand_lo; pc+1; go to HOLD if len=2, else FETCH_HI.
- FETCH_HI: read pc → operand_hi; pc+1; go to HOLD.
- HOLD: `instr_valid`=1; on `instr_valid && instr_ready` go to FETCH_OP.

Memory side:
- In every state except HOLD: `mem_rd`=1 and `mem_addr` = the address above.
- A state advances only in a cycle with `mem_rdy`=1; otherwise it stalls with the address held.
- In HOLD: `mem_rd`=0.
- `mem_addr`/`mem_rd` depend only on state and pc (no combinational path from inputs).

Length rule, applied to the opcode byte `op`:
- len=1 if op[3:0]==4'h8, or op[3:0]==4'hA, or op ∈ {00, 40, 60}.
- Else len=3 if op[3:2]==2'b11, or op[4:0]==5'b11001, or op==20.
- Else len=2.

Output packing:
- Operand bytes not used by the instruction are driven 0.
- `instruction`, `operand_hi`, `instr_len` and `instr_pc` are stable throughout HOLD.

PC arithmetic:
- 16-bit modulo; 0xFFFF+1 wraps to 0x0000, including mid-instruction.

Redirect (`pc_load`):
- Ignored in VEC_LO/VEC_HI.
- In any other state: pc ← `pc_in`; state ← FETCH_OP; any partial instruction is discarded; `instr_valid` is 0 from the next cycle.
- `pc_load` together with a handshake in HOLD: the transfer counts as accepted, and the redirect still applies.
- `pc_load` during a stalled read (`mem_rdy`=0): the read is abandoned.

## Timing
- On `rst` assertion, immediately:
  - all outputs 0 except `mem_addr`=`RESET_VECTOR` and `mem_rd`=1;
  - state = VEC_LO; pc = 0.
- Throughput with `mem_rdy` and `instr_ready` held 1:
  - the first opcode read is in cycle 2 after reset release;
  - a len-N instruction is valid N cycles after its opcode read starts and is held ≥1 cycle;
  - one instruction every N+1 cycles; no prefetch.
- Redirect latency: opcode read at `pc_in` in the cycle after `pc_load`.
- `instr_ready` without `instr_valid` has no effect.

## Structure
- Package `mosby_pkg` holds:
  - the state enum (VEC_LO, VEC_HI, FETCH_OP, FETCH_LO, FETCH_HI, HOLD);
  - the `RESET_VECTOR` default;
  - the length constants.
- Sub-module `opcode_length`: combinational, op[7:0] → len[1:0], implementing the length rule. It is shared later with the decoder.
- Datapath registers in `fetch_unit`: pc, opcode, operand_lo, operand_hi, instr_pc.

## Test plan
- Reset vector: memory FFFC=00, FFFD=80, 8000=EA, `mem_rdy`=1 → `mem_addr` sequence FFFC, FFFD, 8000; `instr_valid` with `instruction`=16'h00EA, len=1, `instr_pc`=8000.
- Immediate: 8000=69, 8001=42 → `instruction`=16'h4269, len=2; next opcode read at 8002.
- Absolute and backpressure: 8000=6D, 34, 12 with `instr_ready`=0 for 5 cycles → outputs {3412, 6D, len=3} stable; `mem_rd`=0 throughout HOLD; next read at 8003 after accept.
- Wait states and wrap: pc=FFFF, FFFF=A9, 0000=07, `mem_rdy` low 2 cycles per read → `instruction`=16'h07A9, `instr_pc`=FFFF; next read at 0001.
- Redirect mid-instruction: `pc_load`=1, `pc_in`=C000 during FETCH_LO of 8000=4C → no valid for 4C; next read at C000.
- Async reset mid-FETCH_HI → outputs zero immediately; restart at FFFC after `rst` release.
